// File: rtl/multiword_add_sequencer.sv
// Word-serial wide-integer add/subtract: operand words arrive LSW-first, the carry is chained
// between words in a register, and one registered sum word is returned per accepted pair.
module multiword_add_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic                  in_sub,
    input  logic                  in_cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0]      out_idx,
    output logic                  out_last,
    output logic                  out_cout,
    output logic                  out_ovf,
    output logic                  proto_err
);

    // Handshake: a word pair moves on in_valid & in_ready, a result on out_valid & out_ready.
    // in_ready = ~out_valid | out_ready, so the single output register gives full throughput.

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]            state_q;
    logic                  carry_q;
    logic                  sub_q;
    logic [CNT_W-1:0]      idx_q;

    logic                  xfer;
    logic                  first_eff;
    logic                  sub_eff;
    logic                  carry_in;
    logic [DATA_WIDTH-1:0] b_eff;
    logic [DATA_WIDTH:0]   core_res;
    logic [CNT_W-1:0]      idx_base;
    logic [CNT_W-1:0]      idx_next;
    logic                  err_now;

    assign in_ready  = ~out_valid | out_ready;
    assign xfer      = in_valid & in_ready;
    assign first_eff = in_first | (state_q == IDLE);
    assign sub_eff   = first_eff ? in_sub : sub_q;
    assign carry_in  = first_eff ? (sub_eff | in_cin) : carry_q;
    assign b_eff     = in_b ^ {DATA_WIDTH{sub_eff}};

    // Adder core: one DATA_WIDTH-bit add with carry in and carry out.
    assign core_res = {1'b0, in_a} + {1'b0, b_eff} + {{DATA_WIDTH{1'b0}}, carry_in};

    assign idx_base = first_eff ? '0 : idx_q;
    assign idx_next = (&idx_base) ? idx_base : idx_base + CNT_W'(1);

    // A lone continuation word, a restart inside an open operation, or running past the
    // last representable index are all protocol violations; the word is still processed.
    assign err_now = (~in_first & (state_q == IDLE))
                   | (in_first & (state_q == RUN))
                   | ((&idx_base) & ~in_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            carry_q   <= 1'b0;
            sub_q     <= 1'b0;
            idx_q     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (xfer) begin
                state_q   <= in_last ? IDLE : RUN;
                carry_q   <= core_res[DATA_WIDTH];
                sub_q     <= sub_eff;
                idx_q     <= idx_next;
                out_valid <= 1'b1;
                out_sum   <= core_res[DATA_WIDTH-1:0];
                out_idx   <= idx_base;
                out_last  <= in_last;
                out_cout  <= core_res[DATA_WIDTH];
                out_ovf   <= (in_a[DATA_WIDTH-1] == b_eff[DATA_WIDTH-1])
                           & (core_res[DATA_WIDTH-1] != in_a[DATA_WIDTH-1]);
                if (err_now) begin
                    proto_err <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Bench for multiword_add_sequencer: random and directed operations checked against a
// wide-integer model of the whole operation, plus reset, backpressure and protocol cases.
module tb_multiword_add_sequencer;

    localparam int W     = 32;
    localparam int CW    = 3;
    localparam int MAXW  = 16;
    localparam int WIDE  = MAXW * W + W;
    localparam int EW    = W + CW + 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_first = 1'b0;
    logic          in_last = 1'b0;
    logic          in_sub = 1'b0;
    logic          in_cin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_sum;
    logic [CW-1:0] out_idx;
    logic          out_last;
    logic          out_cout;
    logic          out_ovf;
    logic          proto_err;

    int checks = 0;
    int errors = 0;
    int ready_mode = 1;

    logic [EW-1:0] exp_q[$];

    logic [W-1:0] op_a [MAXW];
    logic [W-1:0] op_b [MAXW];
    logic [W-1:0] m_sum [MAXW];
    logic         m_cout;
    logic         m_ovf;

    multiword_add_sequencer #(.DATA_WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
        .in_sub(in_sub), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_idx(out_idx), .out_last(out_last),
        .out_cout(out_cout), .out_ovf(out_ovf), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
        else if (ready_mode == 1) out_ready = 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Whole-operation model: operands as one wide integer, borrow handled as A + ~B + 1.
    task automatic model(input int n, input bit sub, input bit cin);
        logic [WIDE-1:0]        wa, wb, ws;
        logic signed [WIDE-1:0] sa, sb, ss, st;
        int sh;
        wa = '0;
        wb = '0;
        for (int i = 0; i < n; i++) begin
            wa[i*W +: W] = op_a[i];
            wb[i*W +: W] = sub ? ~op_b[i] : op_b[i];
        end
        ws = wa + wb + WIDE'(sub ? 1 : cin);
        for (int i = 0; i < n; i++) m_sum[i] = ws[i*W +: W];
        m_cout = ws[n*W];
        sh = WIDE - n * W;
        sa = $signed(wa << sh) >>> sh;
        sb = $signed(wb << sh) >>> sh;
        ss = sa + sb + WIDE'(sub ? 1 : cin);
        st = $signed(ss << sh) >>> sh;
        m_ovf = (st != ss);
    endtask

    task automatic push_exp(input int n, input int nsend, input bit sub, input bit cin);
        logic [CW-1:0] idx;
        model(n, sub, cin);
        for (int i = 0; i < nsend; i++) begin
            idx = (i > (1 << CW) - 1) ? CW'((1 << CW) - 1) : CW'(i);
            exp_q.push_back({m_sum[i], idx, (i == n - 1), m_cout, m_ovf});
        end
    endtask

    task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b,
                             input bit first, input bit last, input bit sub, input bit cin);
        int w;
        in_a = a; in_b = b; in_first = first; in_last = last; in_sub = sub; in_cin = cin;
        in_valid = 1'b1;
        w = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            w++;
            if (w > 300) begin
                chk("send_timeout", 64'(w), 64'd0);
                break;
            end
        end
        if (ready_mode == 1) chk("bubble_wait", 64'(w), 64'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input int n, input bit sub,
                              input bit cin, input bit bad_first);
        for (int i = lo; i < hi; i++) begin
            if (ready_mode == 0 && $urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
            send_word(op_a[i], op_b[i], (i == 0) && !bad_first, (i == n - 1), sub, cin);
        end
    endtask

    task automatic send_op(input int n, input int nsend, input bit sub, input bit cin,
                           input bit bad_first);
        push_exp(n, nsend, sub, cin);
        send_range(0, nsend, n, sub, cin, bad_first);
    endtask

    task automatic gen_words(input int n);
        for (int i = 0; i < n; i++) begin
            op_a[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
            op_b[i] = ($urandom_range(0, 3) == 0) ? 32'h0000_0000 : $urandom();
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 500) begin
            @(posedge clk);
            w++;
        end
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_out_idx", 64'(out_idx), 64'd0);
        chk("rst_flags", 64'({out_last, out_cout, out_ovf}), 64'd0);
        chk("rst_proto_err", 64'(proto_err), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Compare process: every accepted result word against the model, plus stall stability.
    logic          prev_ok = 1'b0;
    logic          prev_stall = 1'b0;
    logic [W+CW+3:0] prev_vec = '0;

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst_n) begin
            chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (prev_ok && prev_stall)
                chk("stall_hold", 64'({out_valid, out_sum, out_idx, out_last, out_cout, out_ovf}),
                    64'(prev_vec));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 64'(out_sum), 64'd0);
                    if (out_sum == '0) chk("unexpected_output_valid", 64'(out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_sum", 64'(out_sum), 64'(e[EW-1 -: W]));
                    chk("out_idx", 64'(out_idx), 64'(e[5:3]));
                    chk("out_last", 64'(out_last), 64'(e[2]));
                    if (e[2]) chk("out_cout_ovf", 64'({out_cout, out_ovf}), 64'(e[1:0]));
                end
            end
        end
        prev_ok    = rst_n;
        prev_stall = out_valid && !out_ready;
        prev_vec   = {out_valid, out_sum, out_idx, out_last, out_cout, out_ovf};
    end

    initial begin
        int n;
        bit sub, cin;
        do_reset();

        // 64-bit add with carry across the word boundary.
        ready_mode = 1;
        op_a[0] = 32'hFFFF_FFFF; op_a[1] = 32'h0000_0001;
        op_b[0] = 32'h0000_0001; op_b[1] = 32'h0000_0000;
        model(2, 1'b0, 1'b0);
        chk("pin1_sum0", 64'(m_sum[0]), 64'h0);
        chk("pin1_sum1", 64'(m_sum[1]), 64'h2);
        chk("pin1_cout_ovf", 64'({m_cout, m_ovf}), 64'd0);
        send_op(2, 2, 1'b0, 1'b0, 1'b0);

        // 3-word subtract of equal operands.
        for (int i = 0; i < 3; i++) begin
            op_a[i] = 32'h1234_5678;
            op_b[i] = 32'h1234_5678;
        end
        model(3, 1'b1, 1'b0);
        chk("pin2_sums", 64'({m_sum[0] | m_sum[1] | m_sum[2]}), 64'h0);
        chk("pin2_cout_ovf", 64'({m_cout, m_ovf}), 64'b10);
        send_op(3, 3, 1'b1, 1'b0, 1'b0);

        // Single-word signed overflow, then 0 - 1 borrow.
        op_a[0] = 32'h7FFF_FFFF; op_b[0] = 32'h0000_0001;
        model(1, 1'b0, 1'b0);
        chk("pin3_sum", 64'(m_sum[0]), 64'h8000_0000);
        chk("pin3_cout_ovf", 64'({m_cout, m_ovf}), 64'b01);
        send_op(1, 1, 1'b0, 1'b0, 1'b0);
        op_a[0] = 32'h0; op_b[0] = 32'h1;
        model(1, 1'b1, 1'b0);
        chk("pin3b_sum", 64'(m_sum[0]), 64'hFFFF_FFFF);
        chk("pin3b_cout_ovf", 64'({m_cout, m_ovf}), 64'b00);
        send_op(1, 1, 1'b1, 1'b0, 1'b0);
        drain();

        // Backpressure mid-operation, then a full-rate finish.
        ready_mode = 2;
        out_ready = 1'b0;
        gen_words(4);
        push_exp(4, 4, 1'b0, 1'b1);
        send_range(0, 1, 4, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        ready_mode = 1;
        out_ready = 1'b1;
        send_range(1, 4, 4, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            gen_words(3);
            send_op(3, 3, k[0], k[1], 1'b0);
        end
        drain();

        // Random legal operations under random backpressure.
        ready_mode = 0;
        for (int k = 0; k < 40; k++) begin
            n = $urandom_range(1, 6);
            sub = $urandom_range(0, 1);
            cin = $urandom_range(0, 1);
            gen_words(n);
            send_op(n, n, sub, cin, 1'b0);
        end
        drain();
        chk("legal_no_proto_err", 64'(proto_err), 64'd0);

        // Restart inside an open operation.
        gen_words(3);
        send_op(3, 1, 1'b1, 1'b0, 1'b0);
        gen_words(2);
        send_op(2, 2, 1'b0, 1'b1, 1'b0);
        drain();
        chk("restart_proto_err", 64'(proto_err), 64'd1);

        // Reset after word 1 of 4, then a fresh op seeded from in_cin.
        ready_mode = 1;
        gen_words(4);
        send_op(4, 1, 1'b0, 1'b0, 1'b0);
        drain();
        do_reset();
        gen_words(2);
        send_op(2, 2, 1'b0, 1'b1, 1'b0);
        drain();
        chk("post_reset_no_err", 64'(proto_err), 64'd0);

        // Continuation word with no open operation.
        gen_words(1);
        send_op(1, 1, 1'b0, 1'b1, 1'b1);
        drain();
        chk("orphan_proto_err", 64'(proto_err), 64'd1);

        // Run past the last index: index saturates and the error flag sets.
        do_reset();
        ready_mode = 0;
        gen_words(9);
        send_op(9, 9, 1'b1, 1'b0, 1'b0);
        drain();
        chk("sat_proto_err", 64'(proto_err), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
